pulse_decoder: RTL and testbench
================================

PULSE_DECODER -- requirements
Module: pulse_decoder

Interface
REQ-001 SHALL have parameter CLK_PER_TICK, default 12000: clocks per timing tick (1 ms at 12 MHz).
REQ-002 SHALL have parameter SYNC_EDGES, default 3: rising edges forming the sync preamble.
REQ-003 SHALL have parameter N_META, default 4: metadata bits per frame.
REQ-004 SHALL have parameter CNT_W, default 8: magnitude width of the bit accumulator.
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 1000: watchdog limit in ticks.
REQ-006 SHALL have parameter DEAD_CYCLES, default 2: clocks with both coil drives off at each polarity change.
REQ-007 SHALL have port CLK_IN, input, 1: sole clock.
REQ-008 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have port DATA_IN, input, 1: asynchronous serial pulse line.
REQ-010 SHALL have port meta_data, output, N_META: last decoded metadata word.
REQ-011 SHALL have port meta_valid, output, 1: one-cycle pulse when meta_data updates.
REQ-012 SHALL have ports coil_pos and coil_neg, output, 1 each: loop current drives.
REQ-013 SHALL have port timeout_err, output, 1: one-cycle pulse on watchdog abort.
REQ-014 SHALL have port state, output, 4: current FSM state code.

Function
REQ-015 SHALL pass DATA_IN through a 2-flop synchroniser; rise = synced high and previous synced low; all decoding uses rise only.
REQ-016 SHALL generate tick, a one-cycle pulse every CLK_PER_TICK clocks, free-running from reset.
REQ-017 SHALL implement states IDLE=0, SYNC=1, BIT_WAIT=2, ADD=3, SUB=4, END_BIT=5, SCAN_WAIT=6, SEND_POS=7, SEND_NEG=8; other codes go to IDLE next cycle.
REQ-018 SHALL go IDLE->SYNC on rise; in SYNC, count rises and go to BIT_WAIT on the rise bringing the total to SYNC_EDGES.
REQ-019 SHALL, in BIT_WAIT on rise, clear the accumulator and go to ADD.
REQ-020 SHALL, in ADD, add 1 to a signed (CNT_W+1)-bit accumulator per tick and go to SUB on rise.
REQ-021 SHALL, in SUB, subtract 1 per tick and go to END_BIT on rise.
REQ-022 SHALL, when tick and rise coincide, apply the tick to the accumulator before the transition.
REQ-023 SHALL saturate the accumulator at +/-(2^CNT_W - 1), with no wrap.
REQ-024 SHALL, in END_BIT (one cycle), store bit = (acc > 0) at index bit_idx, LSB first; tie gives 0.
REQ-025 SHALL, from END_BIT, go to ADD with the accumulator cleared if bits remain; otherwise load meta_data, pulse meta_valid and go to SCAN_WAIT.
REQ-026 SHALL ignore a rise arriving in END_BIT.
REQ-027 SHALL, in SCAN_WAIT, go to SEND_POS on rise; each further rise toggles SEND_POS and SEND_NEG.
REQ-028 SHALL drive coil_pos only in SEND_POS and coil_neg only in SEND_NEG, registered, never both high.
REQ-029 SHALL hold both coils low for DEAD_CYCLES clocks after entry into SEND_POS or SEND_NEG before driving.
REQ-030 SHALL clear the watchdog on every rise and on every state change, and otherwise increment it per tick in every non-IDLE state.
REQ-031 SHALL, when the watchdog reaches TIMEOUT_TICKS, go to IDLE; from SYNC/BIT_WAIT/ADD/SUB/SCAN_WAIT it also pulses timeout_err, and from SEND_POS/SEND_NEG it ends the scan silently.
REQ-032 SHALL give a rise priority over a timeout in the same cycle.
REQ-033 SHALL hold meta_data until the next completed frame; aborted frames never alter it.

Reset
REQ-034 SHALL, while rst_n=0 at a CLK_IN edge, set state=IDLE, meta_data=0, meta_valid=0, coil_pos=0, coil_neg=0, timeout_err=0, and clear the synchroniser, prescaler, watchdog, accumulator and counters.
REQ-035 SHALL abort any frame or scan in progress on reset mid-operation, with coils low on the first cycle after the reset edge.

Structure
REQ-036 SHALL take state codes and the 4-bit state width from shared package mrdust_pkg.
REQ-037 SHALL implement the prescaler as sub-module tick_gen (parameter CLK_PER_TICK, outputs tick).

Verification (CLK_PER_TICK=4, SYNC_EDGES=3, N_META=4, CNT_W=6, TIMEOUT_TICKS=20, DEAD_CYCLES=2)
REQ-038 SHALL cover: 3 sync rises, then bit intervals (ADD/SUB ticks) 5/2, 2/5, 6/1, 3/3 -> meta_data=4'b0101, one meta_valid pulse, state=6.
REQ-039 SHALL cover: valid frame, then 4 scan rises 10 ticks apart -> coil_pos, coil_neg, coil_pos, coil_neg, each delayed 2 clocks after the state change, never both high.
REQ-040 SHALL cover: 2 sync rises, then silence for 20 ticks -> timeout_err pulse, state=0, meta_data unchanged.
REQ-041 SHALL cover: ADD interval of 100 ticks with rises held inside the timeout, then SUB of 1 tick -> accumulator saturates at 63, bit=1.
REQ-042 SHALL cover: rst_n low for one cycle while in SEND_POS -> next cycle state=0, coils low, meta_data=0.
REQ-043 SHALL cover: scan stopped for 20 ticks in SEND_NEG -> state=0, no timeout_err, coils low.

Source files
------------

// File: rtl/mrdust_pkg.sv
// Shared state encoding and sizing helpers for the pulse decoder.
// The state width is fixed so the state code can be exported as a port.
package mrdust_pkg;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 4'd0,
        SYNC      = 4'd1,
        BIT_WAIT  = 4'd2,
        ADD       = 4'd3,
        SUB       = 4'd4,
        END_BIT   = 4'd5,
        SCAN_WAIT = 4'd6,
        SEND_POS  = 4'd7,
        SEND_NEG  = 4'd8
    } state_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pulse_decoder_if.sv
// Bundle of the decoder's serial input and decoded/drive outputs.
// The master side supplies pulses; the slave side is the decoder.
interface pulse_decoder_if
    import mrdust_pkg::*;
#(
    parameter int N_META = 4
);
    logic                data;
    logic [N_META-1:0]   meta_data;
    logic                meta_valid;
    logic                coil_pos;
    logic                coil_neg;
    logic                timeout_err;
    logic [STATE_W-1:0]  state;

    modport master (output data, input meta_data, meta_valid, coil_pos, coil_neg, timeout_err, state);
    modport slave  (input data, output meta_data, meta_valid, coil_pos, coil_neg, timeout_err, state);
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_PER_TICK clocks.
module tick_gen
    import mrdust_pkg::*;
#(
    parameter int CLK_PER_TICK = 12000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick
);
    localparam int W = cnt_w(CLK_PER_TICK);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(CLK_PER_TICK - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni)   cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/pulse_decoder.sv
// Decodes a pulse-interval metadata frame from a serial line, then drives
// alternating coil polarity on each scan pulse, with a tick-based watchdog.
module pulse_decoder
    import mrdust_pkg::*;
#(
    parameter int CLK_PER_TICK  = 12000,
    parameter int SYNC_EDGES    = 3,
    parameter int N_META        = 4,
    parameter int CNT_W         = 8,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int DEAD_CYCLES   = 2
) (
    input  logic               CLK_IN,
    input  logic               rst_n,
    input  logic               DATA_IN,
    output logic [N_META-1:0]  meta_data,
    output logic               meta_valid,
    output logic               coil_pos,
    output logic               coil_neg,
    output logic               timeout_err,
    output logic [STATE_W-1:0] state
);
    localparam int SW = cnt_w(SYNC_EDGES + 1);
    localparam int BW = cnt_w(N_META);
    localparam int WW = cnt_w(TIMEOUT_TICKS + 1);
    localparam int DW = cnt_w(DEAD_CYCLES + 1);
    localparam logic signed [CNT_W:0] ACC_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic signed [CNT_W:0] ACC_MIN = -ACC_MAX;

    logic [1:0]              sync_q;
    logic                    prev_q;
    logic                    rise;
    logic                    tick;
    logic                    timeout;
    state_e                  state_q, state_d;
    logic [SW-1:0]           sync_cnt_q;
    logic signed [CNT_W:0]   acc_q;
    logic [BW-1:0]           bit_idx_q;
    logic [N_META-1:0]       bits_q, bits_d, meta_q;
    logic                    mv_q, pos_q, neg_q, terr_q, terr_d;
    logic [WW-1:0]           wd_q;
    logic [DW-1:0]           dead_q;
    logic                    acc_pos, last_bit;

    tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
        .clk_i  (CLK_IN),
        .rst_ni (rst_n),
        .tick   (tick)
    );

    assign rise     = sync_q[1] & ~prev_q;
    assign timeout  = (wd_q == WW'(TIMEOUT_TICKS));
    assign acc_pos  = !acc_q[CNT_W] && (acc_q != '0);
    assign last_bit = (bit_idx_q == BW'(N_META - 1));

    always_comb begin
        state_d = state_q;
        terr_d  = 1'b0;
        bits_d  = bits_q;
        bits_d[bit_idx_q] = acc_pos;
        case (state_q)
            IDLE:      if (rise) state_d = (SYNC_EDGES <= 1) ? BIT_WAIT : SYNC;
            SYNC:      if (rise && (int'(sync_cnt_q) + 1 >= SYNC_EDGES)) state_d = BIT_WAIT;
            BIT_WAIT:  if (rise) state_d = ADD;
            ADD:       if (rise) state_d = SUB;
            SUB:       if (rise) state_d = END_BIT;
            END_BIT:   state_d = last_bit ? SCAN_WAIT : ADD;
            SCAN_WAIT: if (rise) state_d = SEND_POS;
            SEND_POS:  if (rise) state_d = SEND_NEG;
            SEND_NEG:  if (rise) state_d = SEND_POS;
            default:   state_d = IDLE;
        endcase
        // A rise always wins over an expiring watchdog; a scan ends quietly.
        if (!rise && timeout && state_q != IDLE && state_q != END_BIT) begin
            state_d = IDLE;
            terr_d  = (state_q != SEND_POS) && (state_q != SEND_NEG);
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!rst_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            state_q    <= IDLE;
            sync_cnt_q <= '0;
            acc_q      <= '0;
            bit_idx_q  <= '0;
            bits_q     <= '0;
            meta_q     <= '0;
            mv_q       <= 1'b0;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
            terr_q     <= 1'b0;
            wd_q       <= '0;
            dead_q     <= '0;
        end else begin
            sync_q  <= {sync_q[0], DATA_IN};
            prev_q  <= sync_q[1];
            state_q <= state_d;
            terr_q  <= terr_d;
            mv_q    <= 1'b0;

            if (rise || state_d != state_q)      wd_q <= '0;
            else if (tick && state_q != IDLE)    wd_q <= wd_q + 1'b1;

            if (state_d != state_q)                dead_q <= '0;
            else if (int'(dead_q) < DEAD_CYCLES)   dead_q <= dead_q + 1'b1;

            // Coils drop on the edge that changes state, so the two never overlap.
            pos_q <= (state_d == SEND_POS) && (state_d == state_q) && (int'(dead_q) >= DEAD_CYCLES - 1);
            neg_q <= (state_d == SEND_NEG) && (state_d == state_q) && (int'(dead_q) >= DEAD_CYCLES - 1);

            case (state_q)
                IDLE:     if (rise) sync_cnt_q <= SW'(1);
                SYNC:     if (rise) sync_cnt_q <= sync_cnt_q + 1'b1;
                BIT_WAIT: if (rise) begin
                    acc_q     <= '0;
                    bit_idx_q <= '0;
                end
                ADD:      if (tick && acc_q != ACC_MAX) acc_q <= acc_q + 1'b1;
                SUB:      if (tick && acc_q != ACC_MIN) acc_q <= acc_q - 1'b1;
                END_BIT: begin
                    bits_q    <= bits_d;
                    acc_q     <= '0;
                    bit_idx_q <= bit_idx_q + 1'b1;
                    if (last_bit) begin
                        meta_q <= bits_d;
                        mv_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign meta_data   = meta_q;
    assign meta_valid  = mv_q;
    assign coil_pos    = pos_q;
    assign coil_neg    = neg_q;
    assign timeout_err = terr_q;
    assign state       = state_q;
endmodule

// File: tb/tb_pulse_decoder.sv
// Directed bench: frame decode, scan coil sequencing, watchdog paths, reset
// abort, and accumulator saturation on a second instance with a long watchdog.
module tb_pulse_decoder;
    import mrdust_pkg::*;

    localparam int CPT = 4;
    localparam int NM  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_decoder_if #(.N_META(NM)) ifa ();
    pulse_decoder_if #(.N_META(NM)) ifb ();

    pulse_decoder #(
        .CLK_PER_TICK(CPT), .SYNC_EDGES(3), .N_META(NM), .CNT_W(6),
        .TIMEOUT_TICKS(20), .DEAD_CYCLES(2)
    ) u_a (
        .CLK_IN(clk), .rst_n(rst_n), .DATA_IN(ifa.data),
        .meta_data(ifa.meta_data), .meta_valid(ifa.meta_valid),
        .coil_pos(ifa.coil_pos), .coil_neg(ifa.coil_neg),
        .timeout_err(ifa.timeout_err), .state(ifa.state)
    );

    // Long watchdog so an ADD/SUB interval can run past saturation.
    pulse_decoder #(
        .CLK_PER_TICK(CPT), .SYNC_EDGES(3), .N_META(NM), .CNT_W(6),
        .TIMEOUT_TICKS(150), .DEAD_CYCLES(2)
    ) u_b (
        .CLK_IN(clk), .rst_n(rst_n), .DATA_IN(ifb.data),
        .meta_data(ifb.meta_data), .meta_valid(ifb.meta_valid),
        .coil_pos(ifb.coil_pos), .coil_neg(ifb.coil_neg),
        .timeout_err(ifb.timeout_err), .state(ifb.state)
    );

    int n_pass = 0;
    int n_tot  = 0;
    logic [NM-1:0] qa[$];
    logic [NM-1:0] qb[$];
    int mv_a = 0, mv_b = 0, terr_a = 0, terr_b = 0;
    bit both_seen = 1'b0;
    int ad[4];
    int sb[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot += 1;
        assert (obs === exp) n_pass += 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard pop on every meta_valid; also tallies error pulses and coil overlap.
    always @(negedge clk) begin
        if (ifa.meta_valid) begin
            mv_a += 1;
            chk("meta_a_pending", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) chk("meta_a", 32'(ifa.meta_data), 32'(qa.pop_front()));
        end
        if (ifb.meta_valid) begin
            mv_b += 1;
            chk("meta_b_pending", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) chk("meta_b", 32'(ifb.meta_data), 32'(qb.pop_front()));
        end
        if (ifa.timeout_err) terr_a += 1;
        if (ifb.timeout_err) terr_b += 1;
        if ((ifa.coil_pos && ifa.coil_neg) || (ifb.coil_pos && ifb.coil_neg)) both_seen = 1'b1;
    end

    // Raise the line now (just after an edge) and return exactly gap clocks later.
    task automatic pulse(input int gap, input bit sel);
        if (sel) ifb.data = 1'b1;
        else     ifa.data = 1'b1;
        @(posedge clk); #1;
        ifa.data = 1'b0;
        ifb.data = 1'b0;
        repeat (gap - 1) @(posedge clk);
        #1;
    endtask

    // ADD windows after END_BIT are one clock shorter than the rise spacing, hence +1.
    task automatic frame(input bit sel, input logic [NM-1:0] exp);
        if (sel) qb.push_back(exp);
        else     qa.push_back(exp);
        repeat (3) pulse(8, sel);
        pulse(CPT * ad[0], sel);
        for (int i = 0; i < NM; i++) begin
            pulse(CPT * sb[i], sel);
            pulse((i < NM - 1) ? CPT * ad[i + 1] + 1 : 12, sel);
        end
    endtask

    initial begin
        ifa.data = 1'b0;
        ifb.data = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(ifa.state), 0);
        chk("rst_meta", 32'(ifa.meta_data), 0);
        chk("rst_mv", 32'(ifa.meta_valid), 0);
        chk("rst_coils", 32'({ifa.coil_pos, ifa.coil_neg}), 0);
        chk("rst_terr", 32'(ifa.timeout_err), 0);
        chk("rst_state_b", 32'(ifb.state), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        ad = '{5, 2, 6, 3};
        sb = '{2, 5, 1, 3};
        frame(1'b0, 4'b0101);
        chk("f1_state", 32'(ifa.state), 6);
        chk("f1_mv_cnt", 32'(mv_a), 1);
        chk("f1_meta", 32'(ifa.meta_data), 32'h5);

        for (int k = 0; k < 4; k++) begin
            ifa.data = 1'b1;
            @(posedge clk); #1;
            ifa.data = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("scan_state", 32'(ifa.state), (k % 2) ? 8 : 7);
            chk("scan_dead0", 32'({ifa.coil_pos, ifa.coil_neg}), 0);
            @(posedge clk); #1;
            chk("scan_dead1", 32'({ifa.coil_pos, ifa.coil_neg}), 0);
            @(posedge clk); #1;
            chk("scan_drive", 32'({ifa.coil_pos, ifa.coil_neg}), (k % 2) ? 1 : 2);
            repeat (CPT * 10 - 5) @(posedge clk);
            #1;
        end

        repeat (CPT * 25) @(posedge clk);
        #1;
        chk("scan_stop_state", 32'(ifa.state), 0);
        chk("scan_stop_terr", 32'(terr_a), 0);
        chk("scan_stop_coils", 32'({ifa.coil_pos, ifa.coil_neg}), 0);

        pulse(8, 1'b0);
        pulse(8, 1'b0);
        repeat (CPT * 25) @(posedge clk);
        #1;
        chk("to_terr_cnt", 32'(terr_a), 1);
        chk("to_state", 32'(ifa.state), 0);
        chk("to_meta_kept", 32'(ifa.meta_data), 32'h5);
        chk("to_mv_cnt", 32'(mv_a), 1);

        ad = '{2, 4, 3, 7};
        sb = '{5, 1, 3, 2};
        frame(1'b0, 4'b1010);
        chk("f2_mv_cnt", 32'(mv_a), 2);
        chk("f2_meta", 32'(ifa.meta_data), 32'hA);

        pulse(8, 1'b0);
        chk("pre_rst_state", 32'(ifa.state), 7);
        chk("pre_rst_pos", 32'(ifa.coil_pos), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_state", 32'(ifa.state), 0);
        chk("mid_rst_coils", 32'({ifa.coil_pos, ifa.coil_neg}), 0);
        chk("mid_rst_meta", 32'(ifa.meta_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 63-1 > 0; 63-63 tie; 63-64 < 0; -63 floor; wrap or a wrong limit flips bits.
        ad = '{100, 100, 100, 1};
        sb = '{1, 63, 64, 100};
        frame(1'b1, 4'b0001);
        chk("sat_state", 32'(ifb.state), 6);
        chk("sat_mv_cnt", 32'(mv_b), 1);
        chk("sat_terr", 32'(terr_b), 0);

        repeat (10) @(posedge clk);
        #1;
        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        chk("coils_exclusive", 32'(both_seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
